// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, issues 16-bit reads over a req/ready handshake and feeds decode.
// Optional breakpoint/halt support is enabled by defining FETCH_BKPT_EN.
module instruction_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BrTaken,
    input  logic [15:0] BrAddr,
    input  logic [15:0] MemData,
    input  logic        MemRdy,
    output logic        MemRd,
    output logic [15:0] MemAddr,
    output logic [15:0] Instr,
    output logic        E,
    output logic [15:0] PC,
    output logic        FLTo,
    input  logic [15:0] BkptAddr,
    input  logic        Resume,
    output logic        Halt
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StIssue, StFault} state_e;

    localparam logic [3:0] TimerLast = 4'(TIMEOUT - 1);

    state_e     state;
    logic       squash;
    logic [3:0] timer;
    logic       br_ok;
    logic       br_bad;
    logic       hold;
    logic       issue;

    assign br_ok  = BrTaken && !BrAddr[0] && (state != StFault);
    assign br_bad = BrTaken && BrAddr[0] && (state != StFault);
    // A completed read is only delivered if no redirect is pending or arriving.
    assign issue  = (state == StWait) && MemRdy && !squash && !br_ok;

`ifdef FETCH_BKPT_EN
    logic halt_q;
    logic skip;  // set by Resume so the same PC is fetched once without re-halting

    assign Halt = halt_q;
    assign hold = halt_q || ((PC == BkptAddr) && !skip);
`else
    logic unused_bkpt;

    assign unused_bkpt = ^{BkptAddr, Resume};
    assign Halt        = 1'b0;
    assign hold        = 1'b0;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= StIdle;
            squash  <= 1'b0;
            timer   <= '0;
            PC      <= RESET_PC;
            Instr   <= '0;
            E       <= 1'b0;
            MemRd   <= 1'b0;
            MemAddr <= '0;
            FLTo    <= 1'b0;
`ifdef FETCH_BKPT_EN
            halt_q  <= 1'b0;
            skip    <= 1'b0;
`endif
        end else if (br_bad) begin
            FLTo  <= 1'b1;
            MemRd <= 1'b0;
            E     <= 1'b0;
            state <= StFault;
        end else begin
            unique case (state)
                StIdle: begin
                    if (!Stall && !hold) state <= StReq;
                end
                StReq: begin
                    MemAddr <= PC;
                    MemRd   <= 1'b1;
                    timer   <= '0;
                    state   <= StWait;
                    if (br_ok) squash <= 1'b1;
                end
                StWait: begin
                    if (MemRdy) begin
                        MemRd  <= 1'b0;
                        squash <= 1'b0;
                        if (issue) begin
                            Instr <= MemData;
                            E     <= 1'b1;
                            PC    <= PC + 16'd2;
                            state <= StIssue;
                        end else begin
                            state <= StIdle;
                        end
                    end else if (timer == TimerLast) begin
                        MemRd <= 1'b0;
                        FLTo  <= 1'b1;
                        state <= StFault;
                    end else begin
                        timer <= timer + 4'd1;
                        if (br_ok) squash <= 1'b1;
                    end
                end
                StIssue: begin
                    E     <= 1'b0;
                    state <= StIdle;
                end
                StFault: begin
                    MemRd <= 1'b0;
                    E     <= 1'b0;
                end
                default: state <= StFault;
            endcase
            // Redirect wins over the sequential PC+2 above.
            if (br_ok) PC <= BrAddr;
`ifdef FETCH_BKPT_EN
            if (state == StIdle) begin
                if (halt_q) begin
                    if (Resume) begin
                        halt_q <= 1'b0;
                        skip   <= 1'b1;
                    end
                end else if ((PC == BkptAddr) && !skip) begin
                    halt_q <= 1'b1;
                end
            end
            if (br_ok || issue) skip <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch; breakpoint steps run when FETCH_BKPT_EN is set.
module tb_instruction_fetch;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        BrTaken;
    logic [15:0] BrAddr;
    logic [15:0] MemData;
    logic        MemRdy;
    logic        MemRd;
    logic [15:0] MemAddr;
    logic [15:0] Instr;
    logic        E;
    logic [15:0] PC;
    logic        FLTo;
    logic [15:0] BkptAddr;
    logic        Resume;
    logic        Halt;

    int checks   = 0;
    int failures = 0;
    int e_count  = 0;

    instruction_fetch dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Stall    (Stall),
        .BrTaken  (BrTaken),
        .BrAddr   (BrAddr),
        .MemData  (MemData),
        .MemRdy   (MemRdy),
        .MemRd    (MemRd),
        .MemAddr  (MemAddr),
        .Instr    (Instr),
        .E        (E),
        .PC       (PC),
        .FLTo     (FLTo),
        .BkptAddr (BkptAddr),
        .Resume   (Resume),
        .Halt     (Halt)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) if (E === 1'b1) e_count++;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    // Waits for a request, checks its address, answers after lat WAIT cycles.
    task automatic do_fetch(input int lat, input logic [15:0] data, input logic [15:0] addr);
        int n = 0;
        while (MemRd !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (MemRd !== 1'b1) begin
            check("req_timeout", {15'd0, MemRd}, 16'd1);
            return;
        end
        check("mem_addr", MemAddr, addr);
        for (int i = 1; i < lat; i++) begin
            tick();
            check("rd_held", {15'd0, MemRd}, 16'd1);
        end
        MemRdy  = 1'b1;
        MemData = data;
        tick();
        MemRdy  = 1'b0;
        check("e_high", {15'd0, E}, 16'd1);
        check("instr", Instr, data);
        tick();
        check("e_low", {15'd0, E}, 16'd0);
    endtask

    initial begin
        Stall    = 1'b1;
        BrTaken  = 1'b0;
        BrAddr   = 16'h0000;
        MemData  = 16'h0000;
        MemRdy   = 1'b0;
        BkptAddr = 16'hFFFF;
        Resume   = 1'b0;
        Reset    = 1'b1;
        tick();
        check("rst_pc", PC, 16'h0000);
        check("rst_memrd", {15'd0, MemRd}, 16'd0);
        check("rst_memaddr", MemAddr, 16'h0000);
        check("rst_e", {15'd0, E}, 16'd0);
        check("rst_instr", Instr, 16'h0000);
        check("rst_flt", {15'd0, FLTo}, 16'd0);
        check("rst_halt", {15'd0, Halt}, 16'd0);

        // Single fetch, memory ready on first WAIT cycle.
        Reset = 1'b0;
        Stall = 1'b0;
        tick();
        tick();
        check("t1_memrd", {15'd0, MemRd}, 16'd1);
        check("t1_addr", MemAddr, 16'h0000);
        MemRdy  = 1'b1;
        MemData = 16'h4C01;
        tick();
        MemRdy = 1'b0;
        check("t1_e", {15'd0, E}, 16'd1);
        check("t1_instr", Instr, 16'h4C01);
        check("t1_pc", PC, 16'h0002);
        check("t1_memrd_off", {15'd0, MemRd}, 16'd0);
        tick();
        check("t1_e_off", {15'd0, E}, 16'd0);
        check("t1_instr_hold", Instr, 16'h4C01);

        // Stream of three with 2-cycle latency and a stall between 2nd and 3rd.
        do_reset();
        e_count = 0;
        do_fetch(2, 16'h1111, 16'h0000);
        do_fetch(2, 16'h2222, 16'h0002);
        Stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_stall_memrd", {15'd0, MemRd}, 16'd0);
        end
        check("t2_stall_pc", PC, 16'h0004);
        Stall = 1'b0;
        do_fetch(2, 16'h3333, 16'h0004);
        check("t2_e_count", 16'(e_count), 16'd3);

        // Branch in WAIT squashes the in-flight read.
        while (MemRd !== 1'b1 && e_count < 100) tick();
        BrTaken = 1'b1;
        BrAddr  = 16'h0100;
        tick();
        BrTaken = 1'b0;
        check("t3_pc", PC, 16'h0100);
        check("t3_rd_held", {15'd0, MemRd}, 16'd1);
        MemRdy  = 1'b1;
        MemData = 16'hFFFF;
        tick();
        MemRdy = 1'b0;
        check("t3_no_e", {15'd0, E}, 16'd0);
        check("t3_instr_keep", Instr, 16'h3333);
        check("t3_rd_drop", {15'd0, MemRd}, 16'd0);
        do_fetch(1, 16'hABCD, 16'h0100);
        check("t3_pc_after", PC, 16'h0102);

        // Branch coinciding with MemRdy: data dropped, PC redirected.
        while (MemRd !== 1'b1 && e_count < 100) tick();
        MemRdy  = 1'b1;
        MemData = 16'h9999;
        BrTaken = 1'b1;
        BrAddr  = 16'h0200;
        tick();
        MemRdy  = 1'b0;
        BrTaken = 1'b0;
        check("t3b_no_e", {15'd0, E}, 16'd0);
        check("t3b_pc", PC, 16'h0200);
        check("t3b_instr", Instr, 16'hABCD);
        do_fetch(1, 16'h5555, 16'h0200);

        // Odd branch target faults without updating PC.
        Stall   = 1'b1;
        BrTaken = 1'b1;
        BrAddr  = 16'h0101;
        tick();
        BrTaken = 1'b0;
        Stall   = 1'b0;
        check("t4_flt", {15'd0, FLTo}, 16'd1);
        check("t4_pc", PC, 16'h0202);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_memrd", {15'd0, MemRd}, 16'd0);
        end
        check("t4_pc_frozen", PC, 16'h0202);
        do_reset();
        check("t4_flt_clr", {15'd0, FLTo}, 16'd0);

        // Memory timeout.
        tick();
        tick();
        check("t5_req", {15'd0, MemRd}, 16'd1);
        for (int i = 0; i < 14; i++) tick();
        check("t5_no_flt_yet", {15'd0, FLTo}, 16'd0);
        check("t5_rd_yet", {15'd0, MemRd}, 16'd1);
        tick();
        check("t5_flt", {15'd0, FLTo}, 16'd1);
        check("t5_rd_off", {15'd0, MemRd}, 16'd0);

        // PC wrap from FFFE.
        Stall = 1'b1;
        do_reset();
        BrTaken = 1'b1;
        BrAddr  = 16'hFFFE;
        tick();
        BrTaken = 1'b0;
        check("t5_br_pc", PC, 16'hFFFE);
        Stall = 1'b0;
        do_fetch(1, 16'h7777, 16'hFFFE);
        check("t5_wrap_pc", PC, 16'h0000);
        check("t5_wrap_flt", {15'd0, FLTo}, 16'd0);

        // Breakpoint at 0004.
        BkptAddr = 16'h0004;
        Stall    = 1'b1;
        do_reset();
        Stall = 1'b0;
        do_fetch(1, 16'hA000, 16'h0000);
        do_fetch(1, 16'hA002, 16'h0002);
`ifdef FETCH_BKPT_EN
        tick();
        check("t6_halt", {15'd0, Halt}, 16'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_halt_memrd", {15'd0, MemRd}, 16'd0);
        end
        check("t6_halt_pc", PC, 16'h0004);
        Resume = 1'b1;
        tick();
        Resume = 1'b0;
        check("t6_resume", {15'd0, Halt}, 16'd0);
        do_fetch(1, 16'hA004, 16'h0004);
        check("t6_pc", PC, 16'h0006);
        check("t6_halt_off", {15'd0, Halt}, 16'd0);
`else
        Resume = 1'b1;
        do_fetch(1, 16'hA004, 16'h0004);
        Resume = 1'b0;
        check("t6_nohalt", {15'd0, Halt}, 16'd0);
        check("t6_pc", PC, 16'h0006);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
